// File: rtl/agc_lane_array.sv
// Multi-lane offset-then-scale AGC with saturating requantiser, double-buffered
// coefficients and a windowed saturation/abs-sum statistics engine.
module agc_lane_array #(
    parameter int NSAMP       = 8,
    parameter int DAT_BITS    = 12,
    parameter int OFFSET_BITS = 12,
    parameter int Q_OFFSET    = 8,
    parameter int Q_SCALE     = 12,
    parameter int SCALE_IN    = 5,
    parameter int NFRAC_OUT   = 2,
    parameter int NBITS       = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NSAMP*DAT_BITS-1:0]    dat_i,
    input  logic [16:0]                  scale_i,
    input  logic [OFFSET_BITS-1:0]       offset_i,
    input  logic                         ce_scale_i,
    input  logic                         ce_offset_i,
    input  logic                         apply_i,
    input  logic [15:0]                  window_i,
    input  logic                         stat_start_i,
    input  logic                         stat_ack_i,
    output logic [NSAMP*NBITS-1:0]       out_o,
    output logic [NSAMP*(NBITS-1)-1:0]   abs_o,
    output logic [NSAMP-1:0]             gt_o,
    output logic [NSAMP-1:0]             lt_o,
    output logic [31:0]                  abs_sum_o,
    output logic [31:0]                  gt_count_o,
    output logic [31:0]                  lt_count_o,
    output logic                         stat_valid_o,
    output logic                         stat_mixed_o
);

    localparam int LSB    = Q_OFFSET + Q_SCALE + SCALE_IN - NFRAC_OUT;
    localparam int PRE_W  = 27;
    localparam int PROD_W = 44;
    localparam logic [16:0] UNITY = 17'(1 << Q_SCALE);
    localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((1 << (NBITS-1)) - 1);
    localparam logic signed [PROD_W-1:0] OUT_MIN = PROD_W'(-(1 << (NBITS-1)));

    // Saturation is judged on the whole shifted product so large values never alias.
    function automatic logic [NBITS+1:0] sat_fn(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] r;
        r = p >>> LSB;
        if (r > OUT_MAX) return {2'b10, OUT_MAX[NBITS-1:0]};
        if (r < OUT_MIN) return {2'b01, OUT_MIN[NBITS-1:0]};
        return {2'b00, r[NBITS-1:0]};
    endfunction

    function automatic logic [NBITS-2:0] abs_fn(input logic signed [NBITS-1:0] o);
        logic signed [NBITS-1:0] n;
        n = -o;
        if (!o[NBITS-1]) return o[NBITS-2:0];
        if (n[NBITS-1]) return '1;
        return n[NBITS-2:0];
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 1'b0;
        else         rst_sync_q <= 1'b1;
    end
    assign rst_n = rst_sync_q;

    logic [16:0]                   stg_scale_q, act_scale_q;
    logic signed [OFFSET_BITS-1:0] stg_off_q, act_off_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stg_scale_q <= UNITY;
            act_scale_q <= UNITY;
            stg_off_q   <= '0;
            act_off_q   <= '0;
        end else begin
            if (ce_scale_i)  stg_scale_q <= scale_i;
            if (ce_offset_i) stg_off_q   <= offset_i;
            if (apply_i) begin
                act_scale_q <= stg_scale_q;
                act_off_q   <= stg_off_q;
            end
        end
    end

    logic [NSAMP*DAT_BITS-1:0]     dat_p0_q;
    logic [16:0]                   scale_p0_q, scale_p1_q;
    logic signed [OFFSET_BITS-1:0] off_p0_q;
    logic signed [PRE_W-1:0]       pre_p1_q  [NSAMP];
    logic signed [PROD_W-1:0]      mul_p2_q  [NSAMP];
    logic signed [PROD_W-1:0]      prod_p3_q [NSAMP];
    logic [NSAMP*NBITS-1:0]        out_p4_q, out_d;
    logic [NSAMP*(NBITS-1)-1:0]    abs_p4_q, abs_d;
    logic [NSAMP-1:0]              gt_p4_q, gt_d, lt_p4_q, lt_d;
    logic [NBITS+1:0]              sat_v;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            dat_p0_q   <= '0;
            scale_p0_q <= '0;
            off_p0_q   <= '0;
            scale_p1_q <= '0;
            for (int l = 0; l < NSAMP; l++) begin
                pre_p1_q[l]  <= '0;
                mul_p2_q[l]  <= '0;
                prod_p3_q[l] <= '0;
            end
            out_p4_q <= '0;
            abs_p4_q <= '0;
            gt_p4_q  <= '0;
            lt_p4_q  <= '0;
        end else begin
            // p0: coefficients travel with the sample so an apply never splits a sample
            dat_p0_q   <= dat_i;
            scale_p0_q <= act_scale_q;
            off_p0_q   <= act_off_q;
            // p1: pre-add
            scale_p1_q <= scale_p0_q;
            for (int l = 0; l < NSAMP; l++) begin
                pre_p1_q[l] <= (PRE_W'($signed(dat_p0_q[l*DAT_BITS +: DAT_BITS])) <<< Q_OFFSET)
                               + PRE_W'(off_p0_q);
                // p2: multiply, p3: product register
                mul_p2_q[l]  <= PROD_W'(pre_p1_q[l]) * PROD_W'($signed({1'b0, scale_p1_q}));
                prod_p3_q[l] <= mul_p2_q[l];
            end
            // p4: saturate
            out_p4_q <= out_d;
            abs_p4_q <= abs_d;
            gt_p4_q  <= gt_d;
            lt_p4_q  <= lt_d;
        end
    end

    always_comb begin
        out_d = '0;
        abs_d = '0;
        gt_d  = '0;
        lt_d  = '0;
        sat_v = '0;
        for (int l = 0; l < NSAMP; l++) begin
            sat_v = sat_fn(prod_p3_q[l]);
            out_d[l*NBITS +: NBITS]         = sat_v[NBITS-1:0];
            abs_d[l*(NBITS-1) +: NBITS-1]   = abs_fn(sat_v[NBITS-1:0]);
            gt_d[l]                         = sat_v[NBITS+1];
            lt_d[l]                         = sat_v[NBITS];
        end
    end

    assign out_o = out_p4_q;
    assign abs_o = abs_p4_q;
    assign gt_o  = gt_p4_q;
    assign lt_o  = lt_p4_q;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t      state_q, state_d;
    logic        arm, capture;
    logic [15:0] cnt_q;
    logic        cyc_vld_q, mixed_q;
    logic [31:0] cyc_abs_d, cyc_gt_d, cyc_lt_d;
    logic [31:0] cyc_abs_q, cyc_gt_q, cyc_lt_q;
    logic [31:0] abs_sum_q, gt_cnt_q, lt_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // DRAIN lets the last registered per-cycle sum land before results go valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (stat_start_i && (window_i != 16'd0)) state_d = S_RUN;
            S_RUN:   if (cnt_q == 16'd1) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (stat_ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stat_valid_o = (state_q == S_DONE);
        arm          = (state_q == S_IDLE) && stat_start_i && (window_i != 16'd0);
        capture      = (state_q == S_RUN);
    end

    always_comb begin
        cyc_abs_d = '0;
        cyc_gt_d  = '0;
        cyc_lt_d  = '0;
        for (int l = 0; l < NSAMP; l++) begin
            cyc_abs_d = cyc_abs_d + 32'(abs_p4_q[l*(NBITS-1) +: NBITS-1]);
            cyc_gt_d  = cyc_gt_d + 32'(gt_p4_q[l]);
            cyc_lt_d  = cyc_lt_d + 32'(lt_p4_q[l]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cyc_vld_q <= 1'b0;
            cyc_abs_q <= '0;
            cyc_gt_q  <= '0;
            cyc_lt_q  <= '0;
            abs_sum_q <= '0;
            gt_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            mixed_q   <= 1'b0;
        end else if (arm) begin
            cnt_q     <= window_i;
            cyc_vld_q <= 1'b0;
            abs_sum_q <= '0;
            gt_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            mixed_q   <= 1'b0;
        end else begin
            cyc_vld_q <= capture;
            if (capture) begin
                cnt_q     <= cnt_q - 16'd1;
                cyc_abs_q <= cyc_abs_d;
                cyc_gt_q  <= cyc_gt_d;
                cyc_lt_q  <= cyc_lt_d;
                if (apply_i) mixed_q <= 1'b1;
            end
            if (cyc_vld_q) begin
                abs_sum_q <= sat_add(abs_sum_q, cyc_abs_q);
                gt_cnt_q  <= sat_add(gt_cnt_q, cyc_gt_q);
                lt_cnt_q  <= sat_add(lt_cnt_q, cyc_lt_q);
            end
        end
    end

    assign abs_sum_o    = abs_sum_q;
    assign gt_count_o   = gt_cnt_q;
    assign lt_count_o   = lt_cnt_q;
    assign stat_mixed_o = mixed_q;

endmodule

// File: tb/tb_agc_lane_array.sv
// Directed bench for agc_lane_array: scoreboarded datapath plus statistics and reset checks.
module tb_agc_lane_array;

    localparam int NSAMP    = 8;
    localparam int DAT_BITS = 12;
    localparam int NBITS    = 5;

    logic                        clk = 1'b0;
    logic                        rst_ni = 1'b0;
    logic [NSAMP*DAT_BITS-1:0]   dat = '0;
    logic [16:0]                 scale = 17'd4096;
    logic [11:0]                 offset = '0;
    logic                        ce_scale = 1'b0, ce_offset = 1'b0, apply = 1'b0;
    logic [15:0]                 window = '0;
    logic                        stat_start = 1'b0, stat_ack = 1'b0;
    logic [NSAMP*NBITS-1:0]      out_o;
    logic [NSAMP*(NBITS-1)-1:0]  abs_o;
    logic [NSAMP-1:0]            gt_o, lt_o;
    logic [31:0]                 abs_sum_o, gt_count_o, lt_count_o;
    logic                        stat_valid_o, stat_mixed_o;

    always #5 clk = ~clk;

    agc_lane_array dut (
        .clk_i(clk), .rst_ni(rst_ni), .dat_i(dat), .scale_i(scale), .offset_i(offset),
        .ce_scale_i(ce_scale), .ce_offset_i(ce_offset), .apply_i(apply),
        .window_i(window), .stat_start_i(stat_start), .stat_ack_i(stat_ack),
        .out_o(out_o), .abs_o(abs_o), .gt_o(gt_o), .lt_o(lt_o),
        .abs_sum_o(abs_sum_o), .gt_count_o(gt_count_o), .lt_count_o(lt_count_o),
        .stat_valid_o(stat_valid_o), .stat_mixed_o(stat_mixed_o)
    );

    typedef struct {
        logic [NSAMP*NBITS-1:0]     out;
        logic [NSAMP*(NBITS-1)-1:0] abs;
        logic [NSAMP-1:0]           gt;
        logic [NSAMP-1:0]           lt;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     dat_v[NSAMP];
    longint m_stg_s, m_act_s, m_stg_o, m_act_o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t   e;
        longint p, r;
        int     o, a;
        for (int l = 0; l < NSAMP; l++) begin
            p = ((longint'(dat_v[l]) <<< 8) + m_act_o) * m_act_s;
            r = p >>> 23;
            e.gt[l] = (r > 15);
            e.lt[l] = (r < -16);
            o = (r > 15) ? 15 : (r < -16) ? -16 : int'(r);
            a = (o < 0) ? ((o == -16) ? 15 : -o) : o;
            e.out[l*NBITS +: NBITS]         = 5'(o);
            e.abs[l*(NBITS-1) +: NBITS-1]   = 4'(a);
        end
        return e;
    endfunction

    task automatic drive_dat();
        for (int l = 0; l < NSAMP; l++) dat[l*DAT_BITS +: DAT_BITS] = 12'(dat_v[l]);
    endtask

    task automatic set_all(input int v);
        for (int l = 0; l < NSAMP; l++) dat_v[l] = v;
    endtask

    // Model coefficients return to unity and the pipeline is known to hold zeros.
    task automatic flush_model();
        exp_t z;
        z.out = '0; z.abs = '0; z.gt = '0; z.lt = '0;
        sb.delete();
        for (int i = 0; i < 4; i++) sb.push_back(z);
        m_stg_s = 4096; m_act_s = 4096; m_stg_o = 0; m_act_o = 0;
    endtask

    task automatic tick();
        exp_t e, q;
        drive_dat();
        e = model();
        @(posedge clk);
        if (apply) begin
            m_act_s = m_stg_s;
            m_act_o = m_stg_o;
        end
        if (ce_scale)  m_stg_s = longint'(scale);
        if (ce_offset) m_stg_o = longint'($signed(offset));
        #1;
        sb.push_back(e);
        if (sb.size() >= 5) begin
            q = sb.pop_front();
            check("sb_out", 64'(out_o), 64'(q.out));
            check("sb_abs", 64'(abs_o), 64'(q.abs));
            check("sb_gt",  64'(gt_o),  64'(q.gt));
            check("sb_lt",  64'(lt_o),  64'(q.lt));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out"},   64'(out_o), 64'd0);
        check({tag, "_abs"},   64'(abs_o), 64'd0);
        check({tag, "_gtlt"},  64'({gt_o, lt_o}), 64'd0);
        check({tag, "_sum"},   64'(abs_sum_o), 64'd0);
        check({tag, "_gtc"},   64'(gt_count_o), 64'd0);
        check({tag, "_ltc"},   64'(lt_count_o), 64'd0);
        check({tag, "_valid"}, 64'(stat_valid_o), 64'd0);
        check({tag, "_mixed"}, 64'(stat_mixed_o), 64'd0);
    endtask

    initial begin
        set_all(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");

        // Release; the first edge after release must not capture.
        rst_ni = 1'b1;
        set_all(200);
        drive_dat();
        flush_model();
        @(posedge clk);
        #1;

        set_all(32);
        ticks(6);
        check("unity32_out", 64'(out_o), 64'({NSAMP{5'd4}}));
        check("unity32_abs", 64'(abs_o), 64'({NSAMP{4'd4}}));
        check("unity32_flags", 64'({gt_o, lt_o}), 64'd0);

        set_all(200);
        ticks(6);
        check("pos_sat_out", 64'(out_o), 64'({NSAMP{5'd15}}));
        check("pos_sat_gt",  64'(gt_o), 64'hFF);

        set_all(-200);
        ticks(6);
        check("neg_sat_out", 64'(out_o), 64'({NSAMP{5'b10000}}));
        check("neg_sat_lt",  64'(lt_o), 64'hFF);
        check("neg_sat_abs", 64'(abs_o), 64'({NSAMP{4'hF}}));

        offset = 12'd128; ce_offset = 1'b1; tick(); ce_offset = 1'b0;
        apply = 1'b1; tick(); apply = 1'b0;
        set_all(32);
        ticks(6);
        check("off128_out", 64'(out_o), 64'({NSAMP{5'd4}}));

        offset = -12'sd128; ce_offset = 1'b1; tick(); ce_offset = 1'b0;
        apply = 1'b1; tick(); apply = 1'b0;
        ticks(6);
        check("offm128_out", 64'(out_o), 64'({NSAMP{5'd3}}));
        set_all(0);
        ticks(6);
        check("floor_m1_out", 64'(out_o), 64'({NSAMP{5'b11111}}));
        check("floor_m1_abs", 64'(abs_o), 64'({NSAMP{4'd1}}));

        // ce and apply together: active takes the old staged -128, 0 becomes staged.
        offset = 12'd0; ce_offset = 1'b1; apply = 1'b1; tick(); ce_offset = 1'b0; apply = 1'b0;
        set_all(32);
        ticks(6);
        check("ce_apply_old", 64'(out_o), 64'({NSAMP{5'd3}}));
        apply = 1'b1; tick(); apply = 1'b0;
        ticks(6);
        check("ce_apply_new", 64'(out_o), 64'({NSAMP{5'd4}}));

        scale = 17'd8192; ce_scale = 1'b1; tick(); ce_scale = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int l = 0; l < NSAMP; l++) dat_v[l] = ((l % 2) ? -1 : 1) * (16 + 4 * l + k);
            apply = (k == 5);
            tick();
            apply = 1'b0;
        end
        set_all(32);
        ticks(6);
        check("x2_out", 64'(out_o), 64'({NSAMP{5'd8}}));
        scale = 17'd4096; ce_scale = 1'b1; tick(); ce_scale = 1'b0;
        apply = 1'b1; tick(); apply = 1'b0;

        set_all(200);
        ticks(6);
        window = 16'd10; stat_start = 1'b1; tick(); stat_start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check("w10_valid", 64'(stat_valid_o), 64'(i == 11));
        end
        check("w10_gtc",   64'(gt_count_o), 64'd80);
        check("w10_ltc",   64'(lt_count_o), 64'd0);
        check("w10_sum",   64'(abs_sum_o), 64'd1200);
        check("w10_mixed", 64'(stat_mixed_o), 64'd0);
        window = 16'd3; stat_start = 1'b1; tick(); stat_start = 1'b0;
        ticks(2);
        check("done_hold_valid", 64'(stat_valid_o), 64'd1);
        check("done_hold_gtc",   64'(gt_count_o), 64'd80);
        stat_ack = 1'b1; tick(); stat_ack = 1'b0;
        check("ack_valid", 64'(stat_valid_o), 64'd0);
        stat_ack = 1'b1; tick(); stat_ack = 1'b0;
        check("idle_ack_valid", 64'(stat_valid_o), 64'd0);

        set_all(-200);
        ticks(6);
        window = 16'd4; stat_start = 1'b1; tick(); stat_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            apply = (i == 2);
            stat_start = (i == 3);
            tick();
            apply = 1'b0;
            stat_start = 1'b0;
            check("w4_valid", 64'(stat_valid_o), 64'(i == 5));
        end
        check("w4_ltc",   64'(lt_count_o), 64'd32);
        check("w4_gtc",   64'(gt_count_o), 64'd0);
        check("w4_sum",   64'(abs_sum_o), 64'd480);
        check("w4_mixed", 64'(stat_mixed_o), 64'd1);
        stat_ack = 1'b1; tick(); stat_ack = 1'b0;

        window = 16'd0; stat_start = 1'b1; tick(); stat_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("w0_valid", 64'(stat_valid_o), 64'd0);
        end
        check("w0_sum_kept", 64'(abs_sum_o), 64'd480);

        scale = 17'd8192; ce_scale = 1'b1; tick(); ce_scale = 1'b0;
        apply = 1'b1; tick(); apply = 1'b0;
        set_all(32);
        window = 16'd20; stat_start = 1'b1; tick(); stat_start = 1'b0;
        ticks(3);
        rst_ni = 1'b0;
        #2;
        check_zero_outputs("midrun_rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        set_all(200);
        drive_dat();
        flush_model();
        @(posedge clk);
        #1;
        set_all(32);
        for (int i = 0; i < 25; i++) begin
            tick();
            check("post_rst_valid", 64'(stat_valid_o), 64'd0);
        end
        check("post_rst_unity", 64'(out_o), 64'({NSAMP{5'd4}}));
        check("post_rst_mixed", 64'(stat_mixed_o), 64'd0);
        check("post_rst_sum",   64'(abs_sum_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
